// File: rtl/child_seq_ctrl.sv
// child_seq_ctrl: launches up to NUM_CHILD child instances one at a time, in
// index order, using a per-child start/done handshake.
//
// The parent's single go/done pair drives a sequence:
//   IDLE -> SCAN (walk the latched mask) -> LAUNCH (one-cycle start pulse)
//        -> WAIT (child_done of the launched child) -> SCAN ... -> FINISH.
//
// Optional feature, macro CHILD_SEQ_TIMEOUT_EN:
//   a 16-bit watchdog counts WAIT cycles. A child that stays silent for
//   TIMEOUT cycles is abandoned: err/err_idx are set and the sequence jumps
//   straight to FINISH. Without the macro there is no timer, WAIT holds
//   indefinitely, and err/err_idx are tied low.
//
// child_start and done are flops loaded from the next-state logic, so
// there is no combinational path from any input to any output.

module child_seq_ctrl #(
  parameter int NUM_CHILD = 5,
  parameter int IDX_W     = $clog2(NUM_CHILD + 1),
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [NUM_CHILD-1:0] child_mask,
  input  logic [NUM_CHILD-1:0] child_done,
  output logic [NUM_CHILD-1:0] child_start,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx
);

  // Out-of-range parameters are rejected at elaboration time.
  if (NUM_CHILD < 1 || NUM_CHILD > 15) begin : gBadNumChild
    $error("child_seq_ctrl: NUM_CHILD must be in 1..15");
  end
  if ((1 << IDX_W) < (NUM_CHILD + 1)) begin : gBadIdxW
    $error("child_seq_ctrl: IDX_W too narrow to hold NUM_CHILD");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : gBadTimeout
    $error("child_seq_ctrl: TIMEOUT must be in 2..65535");
  end

  // The mask and done vectors are zero-padded to a power of two so that any
  // value of the index register, including the terminal NUM_CHILD, selects a
  // real bit.
  localparam int PAD_W = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CHILD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_CHILD-1:0]   mask_q, mask_d;
  logic [NUM_CHILD-1:0]   start_q, start_d;
  logic                   done_q, done_d;

  logic [PAD_W-1:0]       maskPad;
  logic [PAD_W-1:0]       donePad;

`ifdef CHILD_SEQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0]            timer_q, timer_d;
  logic                   err_q, err_d;
  logic [IDX_W-1:0]       errIdx_q, errIdx_d;
`endif

  assign maskPad = {{(PAD_W - NUM_CHILD){1'b0}}, mask_q};
  assign donePad = {{(PAD_W - NUM_CHILD){1'b0}}, child_done};

  // Next-state logic: decides the following state, index and output pulses.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    start_d  = '0;
    done_d   = 1'b0;
`ifdef CHILD_SEQ_TIMEOUT_EN
    timer_d  = timer_q;
    err_d    = err_q;
    errIdx_d = errIdx_q;
`endif

    case (state_q)
      IDLE: begin
        if (go) begin
          mask_d   = child_mask;
          idx_d    = '0;
          state_d  = SCAN;
`ifdef CHILD_SEQ_TIMEOUT_EN
          err_d    = 1'b0;
          errIdx_d = '0;
`endif
        end
      end

      SCAN: begin
        if (idx_q == LastIdx) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (!maskPad[idx_q]) begin
          idx_d = idx_q + 1'b1;
        end else begin
          state_d = LAUNCH;
          start_d = NUM_CHILD'(1) << idx_q;
        end
      end

      LAUNCH: begin
        state_d = WAIT;
`ifdef CHILD_SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
      end

      WAIT: begin
        if (donePad[idx_q]) begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
`ifdef CHILD_SEQ_TIMEOUT_EN
        end else if (timer_q == TimeoutLast) begin
          err_d    = 1'b1;
          errIdx_d = idx_q;
          state_d  = FINISH;
          done_d   = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
`endif
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, index, latched mask and the registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

`ifdef CHILD_SEQ_TIMEOUT_EN
  // Watchdog timer and the sticky error report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      err_q    <= 1'b0;
      errIdx_q <= '0;
    end else begin
      timer_q  <= timer_d;
      err_q    <= err_d;
      errIdx_q <= errIdx_d;
    end
  end

  assign err     = err_q;
  assign err_idx = errIdx_q;
`else
  assign err     = 1'b0;
  assign err_idx = '0;
`endif

  assign child_start = start_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign cur_idx     = idx_q;

endmodule
